uart_sample_tx: RTL and testbench

Streams 16-bit audio samples out over an 8N1 UART line as two bytes per sample, low byte first. It is the transmit counterpart of the board's UART sample receiver, which pairs received bytes into samples in the same order. It sits between a sample producer (SID core, test-tone generator, loopback) and the board's RS232 TX pin. A small sample FIFO absorbs producer bursts while the serializer runs at line rate.

---
 rtl/uart_sample_tx_pkg.sv | 15 +
 rtl/uart_sample_tx_if.sv | 9 +
 rtl/uart_sample_tx_txuart.sv | 81 ++++++++
 rtl/uart_sample_tx.sv | 118 +++++++++++
 tb/tb_uart_sample_tx.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_sample_tx_pkg.sv
// Shared constants and state encodings for the UART sample transmitter.
package uart_sample_tx_pkg;

  localparam int unsigned MAIN_CLOCK_FREQ = 12_000_000;
  localparam int unsigned UART_FREQ       = 230_400;
  localparam int unsigned UART_COUNTER    = MAIN_CLOCK_FREQ / UART_FREQ;

  localparam int unsigned START_BITS = 1;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned STOP_BITS  = 1;

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} seq_state_e;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;

endpackage

// File: rtl/uart_sample_tx_if.sv
// Sample producer handshake: valid/ready with a 16-bit sample.
interface uart_sample_tx_if;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;

  modport master (output sample_in, output sample_valid, input sample_ready);
  modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/uart_sample_tx_txuart.sv
// 8N1 byte serializer; tx is registered, so the line lags the state by one cycle.
module uart_sample_tx_txuart
  import uart_sample_tx_pkg::*;
#(
  parameter int unsigned CLOCK_DIVIDE = UART_COUNTER
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_byte,
  input  logic       start,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W = $clog2(CLOCK_DIVIDE);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLOCK_DIVIDE - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end, accept;

  assign bit_end = (timer_q == '0);
  assign accept  = start && !busy;
  assign tx      = tx_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= T_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      T_IDLE:  if (accept) state_d = T_START;
      T_START: if (bit_end) state_d = T_DATA;
      T_DATA:  if (bit_end && idx_q == 3'(DATA_BITS - 1)) state_d = T_STOP;
      T_STOP:  if (bit_end) state_d = accept ? T_START : T_IDLE;
      default: state_d = T_IDLE;
    endcase
  end

  // busy drops on the final stop cycle so a queued byte starts with no gap.
  always_comb begin
    done = (state_q == T_STOP) && bit_end;
    busy = (state_q != T_IDLE) && !done;
    unique case (state_q)
      T_START: tx_d = 1'b0;
      T_DATA:  tx_d = shift_q[idx_q];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (state_q == T_IDLE || bit_end) timer_d = CNT_RELOAD;
    else                              timer_d = timer_q - CNT_W'(1);
    if (state_q == T_START)                idx_d = '0;
    else if (state_q == T_DATA && bit_end) idx_d = idx_q + 3'd1;
    if (accept) shift_d = tx_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= CNT_RELOAD;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_sample_tx.sv
// Sample FIFO plus low/high byte sequencer feeding the UART byte serializer.
module uart_sample_tx
  import uart_sample_tx_pkg::*;
#(
  parameter int unsigned CLOCK_DIVIDE = UART_COUNTER,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  uart_sample_tx_if.slave              s_if,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             full, empty, push, pop;
  logic [15:0]      head;
  logic [7:0]       hold_hi_q;
  seq_state_e       seq_q, seq_d;
  logic             ser_start, ser_busy, ser_done, line_active_q;
  logic [7:0]       ser_byte;

  assign full              = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty             = (level_q == '0);
  assign head              = mem_q[rd_ptr_q];
  assign push              = s_if.sample_valid && !full;
  assign s_if.sample_ready = !full;
  assign fifo_level        = level_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_if.sample_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) seq_q <= S_IDLE;
    else       seq_q <= seq_d;
  end

  always_comb begin
    seq_d = seq_q;
    unique case (seq_q)
      S_IDLE:  if (!empty && !ser_busy) seq_d = S_LOW;
      S_LOW:   if (ser_done) seq_d = S_HIGH;
      S_HIGH:  if (ser_done) seq_d = empty ? S_IDLE : S_LOW;
      default: seq_d = S_IDLE;
    endcase
  end

  // The low byte goes straight from the FIFO head; only the high byte is held.
  always_comb begin
    pop       = 1'b0;
    ser_start = 1'b0;
    ser_byte  = head[7:0];
    unique case (seq_q)
      S_IDLE: if (!empty && !ser_busy) begin
        pop       = 1'b1;
        ser_start = 1'b1;
      end
      S_LOW: if (ser_done) begin
        ser_start = 1'b1;
        ser_byte  = hold_hi_q;
      end
      S_HIGH: if (ser_done && !empty) begin
        pop       = 1'b1;
        ser_start = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_hi_q     <= '0;
      line_active_q <= 1'b0;
    end else begin
      if (pop) hold_hi_q <= head[15:8];
      // Tracks the registered tx line, which trails the serializer state.
      line_active_q <= ser_busy || ser_done;
    end
  end

  assign busy = line_active_q || ser_busy || ser_done || !empty || (seq_q != S_IDLE);

  uart_sample_tx_txuart #(
    .CLOCK_DIVIDE(CLOCK_DIVIDE)
  ) u_txuart (
    .clk     (clk),
    .reset   (reset),
    .tx_byte (ser_byte),
    .start   (ser_start),
    .tx      (tx),
    .busy    (ser_busy),
    .done    (ser_done)
  );

endmodule

// File: tb/tb_uart_sample_tx.sv
// Directed bench: exact line waveforms, a line-decoding receiver, burst and reset cases.
module tb_uart_sample_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx, busy, tx_s, busy_s;
  logic [2:0] level, level_s;

  uart_sample_tx_if s_if ();
  uart_sample_tx_if s_if_s ();

  uart_sample_tx #(.CLOCK_DIVIDE(4), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_if       (s_if),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (level)
  );

  uart_sample_tx dut_slow (
    .clk        (clk),
    .reset      (reset),
    .s_if       (s_if_s),
    .tx         (tx_s),
    .busy       (busy_s),
    .fifo_level (level_s)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [15:0] s, input int b);
    logic [7:0] by;
    int p;
    by = (b < 10) ? s[7:0] : s[15:8];
    p  = b % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return by[p-1];
  endfunction

  function automatic logic cur_tx(input bit slow);
    return slow ? tx_s : tx;
  endfunction

  function automatic logic cur_busy(input bit slow);
    return slow ? busy_s : busy;
  endfunction

  // Single sample into an idle DUT; every line cycle checked against the 8N1 framing.
  task automatic exact_frame(input bit slow, input logic [15:0] s, input string tag);
    int cd, bad;
    cd = slow ? 52 : 4;
    @(negedge clk);
    if (slow) begin s_if_s.sample_in = s; s_if_s.sample_valid = 1'b1; end
    else      begin s_if.sample_in = s;   s_if.sample_valid = 1'b1;   end
    @(negedge clk);
    s_if.sample_valid   = 1'b0;
    s_if_s.sample_valid = 1'b0;
    check_eq({tag, "_level"}, slow ? level_s : level, 1);
    @(negedge clk);
    check_eq({tag, "_pre_start"}, cur_tx(slow), 1'b1);
    for (int b = 0; b < 20; b++) begin
      bad = 0;
      for (int c = 0; c < cd; c++) begin
        @(negedge clk);
        if (cur_tx(slow) !== frame_bit(s, b)) bad++;
      end
      check_eq($sformatf("%s_bit%0d_bad_cycles", tag, b), bad, 0);
    end
    check_eq({tag, "_busy_last_stop"}, cur_busy(slow), 1'b1);
    @(negedge clk);
    check_eq({tag, "_tx_after"}, cur_tx(slow), 1'b1);
    check_eq({tag, "_busy_after"}, cur_busy(slow), 1'b0);
  endtask

  // Line receiver for the CLOCK_DIVIDE=4 DUT: samples each bit in its middle.
  task automatic rx_byte(output logic [7:0] b, output int waited, output bit ok);
    ok = 1'b0;
    b = '0;
    waited = 0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      waited++;
      if (tx === 1'b0) begin ok = 1'b1; break; end
    end
    if (!ok) return;
    repeat (2) @(negedge clk);
    if (tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      b[i] = tx;
    end
    repeat (4) @(negedge clk);
    if (tx !== 1'b1) ok = 1'b0;
    @(negedge clk);
  endtask

  logic [15:0] stim [6];
  logic [7:0]  rx_b [12];
  int          rx_w [12];
  bit          rx_ok [12];
  int          acc, drop_at, busy_low, gap_bad, rx_bad;
  int          lvl [2];
  bit          rx_done, got, rdy;
  logic [7:0]  rb;
  int          rw;
  bit          rok;

  task automatic run_stream(input int n, input int exp_drop, input string tag);
    acc = 0; drop_at = -1; busy_low = 0; gap_bad = 0; rx_bad = 0; rx_done = 1'b0;
    lvl[0] = -1; lvl[1] = -1;
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < n; i++) begin
          s_if.sample_in    = stim[i];
          s_if.sample_valid = 1'b1;
          got = 1'b0;
          for (int t = 0; t < 1000 && !got; t++) begin
            rdy = s_if.sample_ready;
            if (!rdy && drop_at < 0) drop_at = acc;
            @(posedge clk);
            got = rdy;
            @(negedge clk);
          end
          if (got) begin
            acc++;
            if (acc <= 2) lvl[acc-1] = int'(level);
          end
        end
        s_if.sample_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 2 * n; j++) begin
          rx_byte(rb, rw, rok);
          rx_b[j] = rb; rx_w[j] = rw; rx_ok[j] = rok;
          if (!rok) rx_bad++;
          if (j > 0 && rw != 1) gap_bad++;
        end
        rx_done = 1'b1;
      end
      begin
        @(posedge clk);
        while (!rx_done) begin
          @(negedge clk);
          if (!rx_done && busy !== 1'b1) busy_low++;
        end
      end
    join
    check_eq({tag, "_accepted"}, acc, n);
    check_eq({tag, "_ready_drop_after"}, drop_at, exp_drop);
    check_eq({tag, "_level_first_push"}, lvl[0], 1);
    if (n >= 2) check_eq({tag, "_level_push_pop"}, lvl[1], 1);
    check_eq({tag, "_framing_errors"}, rx_bad, 0);
    check_eq({tag, "_idle_gaps"}, gap_bad, 0);
    check_eq({tag, "_busy_low_cycles"}, busy_low, 0);
    for (int j = 0; j < n; j++)
      check_eq($sformatf("%s_sample%0d", tag, j), {rx_b[2*j+1], rx_b[2*j]}, stim[j]);
    repeat (5) @(negedge clk);
  endtask

  int idle_bad;

  initial begin
    reset = 1'b1;
    s_if.sample_valid = 1'b0;   s_if.sample_in = '0;
    s_if_s.sample_valid = 1'b0; s_if_s.sample_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_ready", s_if.sample_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_level", level, 0);
    check_eq("rst_slow_tx", tx_s, 1'b1);
    check_eq("rst_slow_level", level_s, 0);

    idle_bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) idle_bad++;
    end
    check_eq("idle_line", idle_bad, 0);

    exact_frame(1'b0, 16'h1234, "s1234");

    for (int i = 0; i < 6; i++) stim[i] = 16'(i + 1);
    run_stream(6, 5, "burst");

    stim[0] = 16'h0000; stim[1] = 16'hFFFF; stim[2] = 16'h8001; stim[3] = 16'h7FFE;
    run_stream(4, -1, "loop");

    // Reset lands in the data bits of the high byte with a second sample queued.
    @(negedge clk);
    s_if.sample_in = 16'hA5C3; s_if.sample_valid = 1'b1;
    @(negedge clk);
    s_if.sample_in = 16'h0F0F;
    @(negedge clk);
    s_if.sample_valid = 1'b0;
    check_eq("mid_level_before", level, 1);
    repeat (58) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_tx", tx, 1'b1);
    check_eq("mid_rst_level", level, 0);
    check_eq("mid_rst_ready", s_if.sample_ready, 1'b1);
    check_eq("mid_rst_busy", busy, 1'b0);
    idle_bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) idle_bad++;
    end
    check_eq("mid_rst_no_resend", idle_bad, 0);
    stim[0] = 16'h3C5A;
    run_stream(1, -1, "post_rst");

    exact_frame(1'b1, 16'h55AA, "slow55aa");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
